cpu_ctrl_seq: RTL and testbench

CPU_CTRL_SEQ -- requirements
Module: cpu_ctrl_seq

---
 rtl/cpu_ctrl_seq.sv | 118 +++++++++++
 tb/tb_cpu_ctrl_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle CPU control sequencer: one registered state drives all datapath enables.
// Memory states stretch by MEM_WAIT cycles; stall freezes everything; irq is taken at instruction end.
module cpu_ctrl_seq #(
  parameter int TYPE_W   = 3,
  parameter int MEM_WAIT = 0,
  parameter int IRQ_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TYPE_W-1:0] instr_type,
  input  logic              stall,
  input  logic              irq,
  input  logic              resume,
  output logic              pc_en,
  output logic              ir_en,
  output logic              r_en,
  output logic              alu_bus_en,
  output logic              reg_read,
  output logic              mem_we,
  output logic              flags_en,
  output logic              link_en,
  output logic              irq_ack,
  output logic              vec_sel,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        state_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_STORE_ADDR = 4'd3,
    S_LOAD_ADDR = 4'd4, S_LOAD_WB = 4'd5, S_STORE_HOLD = 4'd6, S_JUMP = 4'd7,
    S_BRANCH = 4'd8, S_JAL = 4'd9, S_HALT = 4'd10, S_IRQ_SAVE = 4'd11, S_IRQ_VEC = 4'd12
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state, state_nxt, after_term;
  logic [3:0] wcnt, wcnt_nxt;
  logic       irq_i, type_bad;

  assign irq_i    = (IRQ_EN != 0) && irq;
  assign type_bad = 32'(instr_type) > 32'd6;
  assign state_o  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      wcnt    <= WAIT_INIT;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state == S_DECODE && type_bad) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    after_term = irq_i ? S_IRQ_SAVE : S_FETCH;
    if (!stall) begin
      case (state)
        S_FETCH, S_STORE_ADDR, S_LOAD_ADDR: begin
          if (wcnt != 4'd0) wcnt_nxt = wcnt - 4'd1;
          else if (state == S_FETCH) state_nxt = S_DECODE;
          else if (state == S_STORE_ADDR) state_nxt = S_STORE_HOLD;
          else state_nxt = S_LOAD_WB;
        end
        S_DECODE: begin
          case (instr_type)
            TYPE_W'(0): state_nxt = S_EXEC_R;
            TYPE_W'(1): state_nxt = S_STORE_ADDR;
            TYPE_W'(2): state_nxt = S_LOAD_ADDR;
            TYPE_W'(3): state_nxt = S_JUMP;
            TYPE_W'(4): state_nxt = S_BRANCH;
            TYPE_W'(5): state_nxt = S_JAL;
            TYPE_W'(6): state_nxt = S_HALT;
            default:    state_nxt = S_FETCH;
          endcase
        end
        // irq wins over resume when both arrive in HALT
        S_HALT: begin
          if (irq_i) state_nxt = S_IRQ_SAVE;
          else if (resume) state_nxt = S_FETCH;
        end
        S_IRQ_SAVE: state_nxt = S_IRQ_VEC;
        S_IRQ_VEC:  state_nxt = S_FETCH;
        default:    state_nxt = after_term;
      endcase
      // every entry into a state reloads the wait count
      if (state_nxt != state) wcnt_nxt = WAIT_INIT;
    end
  end

  always_comb begin
    pc_en = 1'b0; ir_en = 1'b0; r_en = 1'b0; alu_bus_en = 1'b0;
    reg_read = 1'b0; mem_we = 1'b0; flags_en = 1'b0; link_en = 1'b0;
    irq_ack = 1'b0; vec_sel = 1'b0; halted = 1'b0;
    case (state)
      S_FETCH:      begin ir_en = 1'b1; alu_bus_en = 1'b1; end
      S_DECODE:     begin alu_bus_en = 1'b1; link_en = 1'b1; pc_en = (instr_type != TYPE_W'(5)); end
      S_EXEC_R:     begin r_en = 1'b1; alu_bus_en = 1'b1; flags_en = 1'b1; end
      S_STORE_ADDR: begin reg_read = 1'b1; mem_we = 1'b1; end
      S_LOAD_ADDR:  reg_read = 1'b1;
      S_LOAD_WB:    r_en = 1'b1;
      S_STORE_HOLD, S_JUMP, S_BRANCH: alu_bus_en = 1'b1;
      S_JAL:        begin r_en = 1'b1; reg_read = 1'b1; link_en = 1'b1; end
      S_HALT:       halted = 1'b1;
      S_IRQ_SAVE:   begin irq_ack = 1'b1; link_en = 1'b1; r_en = 1'b1; end
      S_IRQ_VEC:    begin vec_sel = 1'b1; pc_en = 1'b1; end
      default:      ;
    endcase
    if (stall) begin
      pc_en = 1'b0; ir_en = 1'b0; r_en = 1'b0; mem_we = 1'b0; flags_en = 1'b0; irq_ack = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: three configurations (wait 0, wait 2, irq disabled) share stimulus;
// directed scenarios plus random cycles against a table-driven reference model.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0, reset;
  logic [2:0] instr_type;
  logic       stall, irq, resume;
  logic [2:0] pc_en, ir_en, r_en, alu_bus_en, reg_read, mem_we, flags_en, link_en;
  logic [2:0] irq_ack, vec_sel, halted, illegal;
  logic [3:0] st [3];

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    cpu_ctrl_seq #(.TYPE_W(3), .MEM_WAIT(k == 1 ? 2 : 0), .IRQ_EN(k == 2 ? 0 : 1)) u (
      .clk(clk), .reset(reset), .instr_type(instr_type), .stall(stall), .irq(irq), .resume(resume),
      .pc_en(pc_en[k]), .ir_en(ir_en[k]), .r_en(r_en[k]), .alu_bus_en(alu_bus_en[k]),
      .reg_read(reg_read[k]), .mem_we(mem_we[k]), .flags_en(flags_en[k]), .link_en(link_en[k]),
      .irq_ack(irq_ack[k]), .vec_sel(vec_sel[k]), .halted(halted[k]), .illegal(illegal[k]),
      .state_o(st[k]));
  end

  // reference model: states as plain integers, wait as "cycles still to hold"
  int mw_tab [3] = '{0, 2, 0};
  bit ie_tab [3] = '{1'b1, 1'b1, 1'b0};
  int dec_tab [8] = '{2, 3, 4, 7, 8, 9, 10, 0};
  int ms [3], mrem [3];
  bit mill [3];

  localparam logic [10:0] PC = 11'h400, IR = 11'h200, RE = 11'h100, AB = 11'h080, RR = 11'h040,
                          MW = 11'h020, FL = 11'h010, LK = 11'h008, IA = 11'h004, VS = 11'h002,
                          HL = 11'h001;

  function automatic logic [10:0] outs(int k);
    return {pc_en[k], ir_en[k], r_en[k], alu_bus_en[k], reg_read[k], mem_we[k], flags_en[k],
            link_en[k], irq_ack[k], vec_sel[k], halted[k]};
  endfunction

  function automatic logic [10:0] exp_outs(int s, int ty, bit stl);
    logic [10:0] v;
    case (s)
      0: v = IR | AB;
      1: v = AB | LK | ((ty != 5) ? PC : 11'h0);
      2: v = RE | AB | FL;
      3: v = RR | MW;
      4: v = RR;
      5: v = RE;
      6, 7, 8: v = AB;
      9: v = RE | RR | LK;
      10: v = HL;
      11: v = IA | LK | RE;
      12: v = VS | PC;
      default: v = 11'h0;
    endcase
    if (stl) v &= ~(PC | IR | RE | MW | FL | IA);
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin ms[k] = 0; mrem[k] = mw_tab[k]; mill[k] = 1'b0; end
  endfunction

  function automatic void model_step();
    int nx;
    bit ie;
    for (int k = 0; k < 3; k++) begin
      if (ms[k] == 1 && int'(instr_type) > 6) mill[k] = 1'b1;
      if (stall) continue;
      ie = ie_tab[k] && irq;
      nx = ms[k];
      case (ms[k])
        0, 3, 4: if (mrem[k] > 0) mrem[k]--; else nx = (ms[k] == 0) ? 1 : (ms[k] == 3) ? 6 : 5;
        1: nx = dec_tab[instr_type];
        10: nx = ie ? 11 : (resume ? 0 : 10);
        11: nx = 12;
        12: nx = 0;
        default: nx = ie ? 11 : 0;
      endcase
      if (nx != ms[k]) mrem[k] = mw_tab[k];
      ms[k] = nx;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; irq = 1'b0; resume = 1'b0; instr_type = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; irq = 1'b0; resume = 1'b0; instr_type = 3'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (st[k] !== 4'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d want 0", k, st[k]); end
      checks++;
      if (illegal[k] !== 1'b0) begin errors++; $display("FAIL reset_illegal dut%0d got %b want 0", k, illegal[k]); end
      checks++;
      if (outs(k) !== (IR | AB)) begin errors++; $display("FAIL reset_outs dut%0d got %h want %h", k, outs(k), IR | AB); end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    int seq [4] = '{0, 1, 2, 0};
    int nr = 0, nf = 0;
    do_reset();
    instr_type = 3'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (st[0] !== 4'(seq[i])) begin errors++; $display("FAIL rtype_state cyc%0d got %0d want %0d", i, st[0], seq[i]); end
      nr += int'(r_en[0]); nf += int'(flags_en[0]);
      @(negedge clk);
    end
    checks++;
    if (nr != 1 || nf != 1) begin errors++; $display("FAIL rtype_pulse r_en %0d flags_en %0d cycles want 1 1", nr, nf); end
  endtask

  task automatic test_load();
    int seq [9] = '{0, 0, 0, 1, 4, 4, 4, 5, 0};
    do_reset();
    instr_type = 3'd2;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (st[1] !== 4'(seq[i])) begin errors++; $display("FAIL load_state cyc%0d got %0d want %0d", i, st[1], seq[i]); end
      checks++;
      if (reg_read[1] !== (seq[i] == 4) || r_en[1] !== (seq[i] == 5))
        begin errors++; $display("FAIL load_en cyc%0d reg_read %b r_en %b state %0d", i, reg_read[1], r_en[1], seq[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int seq [13] = '{0, 0, 0, 1, 3, 3, 3, 3, 3, 3, 3, 6, 0};
    bit stl [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    do_reset();
    instr_type = 3'd1;
    for (int i = 0; i < 13; i++) begin
      stall = stl[i];
      #1;
      checks++;
      if (st[1] !== 4'(seq[i])) begin errors++; $display("FAIL stall_state cyc%0d got %0d want %0d", i, st[1], seq[i]); end
      checks++;
      if (mem_we[1] !== (seq[i] == 3 && !stl[i]) || reg_read[1] !== (seq[i] == 3))
        begin errors++; $display("FAIL stall_en cyc%0d mem_we %b reg_read %b", i, mem_we[1], reg_read[1]); end
      @(negedge clk);
    end
    stall = 1'b0;
  endtask

  task automatic test_irq();
    int seq0 [6] = '{0, 1, 7, 11, 12, 0};
    int seq2 [6] = '{0, 1, 7, 0, 1, 7};
    int nack = 0;
    do_reset();
    instr_type = 3'd3;
    for (int i = 0; i < 6; i++) begin
      irq = (i == 2);
      #1;
      checks++;
      if (st[0] !== 4'(seq0[i])) begin errors++; $display("FAIL irq_state cyc%0d got %0d want %0d", i, st[0], seq0[i]); end
      checks++;
      if (st[2] !== 4'(seq2[i])) begin errors++; $display("FAIL irq_off_state cyc%0d got %0d want %0d", i, st[2], seq2[i]); end
      checks++;
      if (vec_sel[0] !== (seq0[i] == 12) || (seq0[i] == 12 && pc_en[0] !== 1'b1) || irq_ack[2] !== 1'b0)
        begin errors++; $display("FAIL irq_vec cyc%0d vec_sel %b pc_en %b ack_off %b", i, vec_sel[0], pc_en[0], irq_ack[2]); end
      nack += int'(irq_ack[0]);
      @(negedge clk);
    end
    irq = 1'b0;
    checks++;
    if (nack != 1) begin errors++; $display("FAIL irq_ack_pulse got %0d cycles want 1", nack); end
  endtask

  task automatic test_halt();
    int seq [10] = '{0, 1, 10, 10, 10, 0, 1, 10, 11, 12};
    do_reset();
    instr_type = 3'd6;
    for (int i = 0; i < 10; i++) begin
      resume = (i == 4);
      irq = (i == 7);
      #1;
      checks++;
      if (st[0] !== 4'(seq[i])) begin errors++; $display("FAIL halt_state cyc%0d got %0d want %0d", i, st[0], seq[i]); end
      checks++;
      if (halted[0] !== (seq[i] == 10)) begin errors++; $display("FAIL halt_flag cyc%0d got %b", i, halted[0]); end
      @(negedge clk);
    end
    resume = 1'b0; irq = 1'b0;
  endtask

  task automatic test_illegal_reset();
    int seq [5] = '{0, 1, 0, 1, 4};
    bit ill [5] = '{0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      instr_type = (i < 2) ? 3'd7 : 3'd2;
      #1;
      checks++;
      if (st[0] !== 4'(seq[i]) || illegal[0] !== ill[i])
        begin errors++; $display("FAIL illegal_seq cyc%0d state %0d want %0d illegal %b want %b", i, st[0], seq[i], illegal[0], ill[i]); end
      if (i < 4) @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (st[0] !== 4'd0 || st[1] !== 4'd0 || illegal[0] !== 1'b0)
      begin errors++; $display("FAIL async_reset state %0d/%0d illegal %b want 0/0 0", st[0], st[1], illegal[0]); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      instr_type = 3'($urandom_range(0, 7));
      stall      = ($urandom_range(0, 3) == 0);
      irq        = ($urandom_range(0, 5) == 0);
      resume     = !irq && ($urandom_range(0, 2) == 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (st[k] !== 4'(ms[k]) || illegal[k] !== mill[k] || outs(k) !== exp_outs(ms[k], int'(instr_type), stall))
          begin
            errors++;
            $display("FAIL random cyc%0d dut%0d state %0d want %0d illegal %b want %b outs %h want %h",
                     c, k, st[k], ms[k], illegal[k], mill[k], outs(k), exp_outs(ms[k], int'(instr_type), stall));
          end
      end
      model_step();
      @(negedge clk);
    end
    stall = 1'b0; irq = 1'b0; resume = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; irq = 1'b0; resume = 1'b0; instr_type = 3'd0;
    test_reset();
    test_rtype();
    test_load();
    test_stall();
    test_irq();
    test_halt();
    test_illegal_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
